// File: rtl/fighter_motion_ctrl_if.sv
// fighter_motion_ctrl_if: buttons/opponent in, fighter state out.
// master = button source, slave = motion controller.
interface fighter_motion_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_attack;
  logic [6:0] opp_x;
  logic [6:0] x;
  logic [6:0] y;
  logic       in_air;
  logic [1:0] move_state;
  logic [2:0] character_state;
  logic       mirror;
  logic       tick;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, btn_attack, opp_x,
    input  x, y, in_air, move_state, character_state, mirror, tick
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, btn_attack, opp_x,
    output x, y, in_air, move_state, character_state, mirror, tick
  );
endinterface

// File: rtl/fighter_motion_ctrl.sv
// fighter_motion_ctrl: tick-rate walk, jump, attack and combo control.
// FIGHTER_SUPER_COMBO_EN: 8-deep history, U,D,U,D,L,R,L,R super move.
module fighter_motion_ctrl #(
  parameter int TICK_DIV     = 3_125_000,
  parameter int X_MIN        = 8,
  parameter int X_MAX        = 88,
  parameter int X_INIT       = 24,
  parameter int Y_GROUND     = 40,
  parameter int STEP         = 1,
  parameter int JUMP_V0      = 6,
  parameter int PUNCH_TICKS  = 12,
  parameter int SP_TICKS     = 24,
  parameter int COMBO_WINDOW = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fighter_motion_ctrl_if.slave  io
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_PUNCH   = 3'b001,
    ST_SPECIAL = 3'b010,
    ST_SUPER   = 3'b011
  } st_e;

`ifdef FIGHTER_SUPER_COMBO_EN
  localparam int HD = 8;
`else
  localparam int HD = 3;
`endif
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(2 * SP_TICKS + 1);
  localparam int GW = $clog2(COMBO_WINDOW + 2);
  localparam int NW = $clog2(HD + 1);

  localparam logic [1:0] D_L = 2'd0;
  localparam logic [1:0] D_D = 2'd1;
  localparam logic [1:0] D_R = 2'd2;
  localparam logic [1:0] D_U = 2'd3;

  localparam logic [1:0] MS_FWD = 2'b01;
  localparam logic [1:0] MS_BWD = 2'b10;

  localparam logic [7:0] XMIN8 = 8'(X_MIN);
  localparam logic [7:0] XMAX8 = 8'(X_MAX);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [7:0] YG8   = 8'(Y_GROUND);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          btn_q, btn_d;
  logic [6:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [4:0]          vy_q, vy_d;
  logic                air_q, air_d;
  logic [1:0]          ms_q, ms_d;
  st_e                 st_q, st_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                mir_q, mir_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [HD-1:0][1:0]  hist_q, hist_d;
  logic [NW-1:0]       hn_q, hn_d;

  logic                tick_w;
  logic [4:0]          btn_w;
  logic [4:0]          edg;
  logic                idle;
  logic                jump;
  logic                air_v;
  logic [4:0]          vy_v;
  logic [7:0]          y_nx;
  logic [7:0]          x_w;
  logic [7:0]          x_nx;
  logic                go_l;
  logic                go_r;
  logic [GW-1:0]       gap_nx;
  logic [2:0]          ndir;
  logic [1:0]          code;
  logic [HD-1:0][1:0]  hist_v;
  logic [NW-1:0]       hn_v;
  logic                ldr;
  logic                sup;

  assign tick_w = (cnt_q == CW'(TICK_DIV - 1));
  assign btn_w  = {io.btn_attack, io.btn_down, io.btn_up,
                   io.btn_right, io.btn_left};

  // Next-state: jump physics, then walk, then combo/attack on each tick
  always_comb begin
    cnt_d  = tick_w ? '0 : cnt_q + 1'b1;
    btn_d  = btn_q;
    x_d    = x_q;
    y_d    = y_q;
    vy_d   = vy_q;
    air_d  = air_q;
    ms_d   = ms_q;
    st_d   = st_q;
    tmr_d  = tmr_q;
    mir_d  = mir_q;
    gap_d  = gap_q;
    hist_d = hist_q;
    hn_d   = hn_q;
    edg    = '0;
    idle   = (st_q == ST_IDLE);
    jump   = 1'b0;
    air_v  = air_q;
    vy_v   = vy_q;
    y_nx   = '0;
    x_w    = {1'b0, x_q};
    x_nx   = {1'b0, x_q};
    go_l   = 1'b0;
    go_r   = 1'b0;
    gap_nx = gap_q;
    ndir   = '0;
    code   = D_U;
    hist_v = hist_q;
    hn_v   = hn_q;
    ldr    = 1'b0;
    sup    = 1'b0;
    if (tick_w) begin
      btn_d = btn_w;
      edg   = btn_w & ~btn_q;
      jump  = edg[2] & ~air_q & idle;
      air_v = air_q | jump;
      vy_v  = jump ? 5'(JUMP_V0) : vy_q;
      y_nx  = {1'b0, y_q} - {{3{vy_v[4]}}, vy_v};
      if (air_v) begin
        if ($signed(y_nx) >= $signed(YG8)) begin
          y_d   = YG8[6:0];
          air_d = 1'b0;
          vy_d  = '0;
        end else begin
          y_d   = y_nx[6:0];
          air_d = 1'b1;
          vy_d  = vy_v - 5'd1;
        end
      end

      go_l = btn_w[0] & ~btn_w[1] & idle;
      go_r = btn_w[1] & ~btn_w[0] & idle;
      ms_d = 2'b00;
      if (go_r && x_w < XMAX8) begin
        x_nx = (x_w + STEP8 > XMAX8) ? XMAX8 : x_w + STEP8;
        ms_d = (io.opp_x > x_q) ? MS_FWD : MS_BWD;
      end else if (go_l && x_w > XMIN8) begin
        x_nx = (x_w < XMIN8 + STEP8) ? XMIN8 : x_w - STEP8;
        ms_d = (io.opp_x < x_q) ? MS_FWD : MS_BWD;
      end
      x_d = x_nx[6:0];
      if ({1'b0, io.opp_x} < x_nx) begin
        mir_d = 1'b1;
      end else if ({1'b0, io.opp_x} > x_nx) begin
        mir_d = 1'b0;
      end

      ndir = 3'(edg[0]) + 3'(edg[1]) + 3'(edg[2]) + 3'(edg[3]);
      gap_nx = (gap_q > GW'(COMBO_WINDOW)) ? gap_q : gap_q + 1'b1;
      if (gap_nx > GW'(COMBO_WINDOW)) begin
        hist_v = '0;
        hn_v   = '0;
      end
      gap_d = gap_nx;
      if (ndir == 3'd1) begin
        unique case (1'b1)
          edg[0]:  code = D_L;
          edg[3]:  code = D_D;
          edg[1]:  code = D_R;
          default: code = D_U;
        endcase
        hist_v = {hist_v[HD-2:0], code};
        hn_v   = (hn_v == NW'(HD)) ? hn_v : hn_v + 1'b1;
        gap_d  = '0;
      end else if (ndir > 3'd1) begin
        hist_v = '0;
        hn_v   = '0;
        gap_d  = '0;
      end
      ldr = (hn_v >= NW'(3)) && (hist_v[2] == D_L) &&
            (hist_v[1] == D_D) && (hist_v[0] == D_R);
`ifdef FIGHTER_SUPER_COMBO_EN
      sup = (hn_v == NW'(8)) &&
            (hist_v == {D_U, D_D, D_U, D_D, D_L, D_R, D_L, D_R});
`endif
      hist_d = hist_v;
      hn_d   = hn_v;

      if (idle) begin
        if (edg[4]) begin
          hist_d = '0;
          hn_d   = '0;
          if (sup && !air_d) begin
            st_d  = ST_SUPER;
            tmr_d = TW'(2 * SP_TICKS);
          end else if (ldr && !air_d) begin
            st_d  = ST_SPECIAL;
            tmr_d = TW'(SP_TICKS);
          end else begin
            st_d  = ST_PUNCH;
            tmr_d = TW'(PUNCH_TICKS);
          end
        end
      end else begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == TW'(1)) begin
          st_d = ST_IDLE;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      btn_q  <= '0;
      x_q    <= 7'(X_INIT);
      y_q    <= 7'(Y_GROUND);
      vy_q   <= '0;
      air_q  <= 1'b0;
      ms_q   <= 2'b00;
      st_q   <= ST_IDLE;
      tmr_q  <= '0;
      mir_q  <= 1'b0;
      gap_q  <= '0;
      hist_q <= '0;
      hn_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      btn_q  <= btn_d;
      x_q    <= x_d;
      y_q    <= y_d;
      vy_q   <= vy_d;
      air_q  <= air_d;
      ms_q   <= ms_d;
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      mir_q  <= mir_d;
      gap_q  <= gap_d;
      hist_q <= hist_d;
      hn_q   <= hn_d;
    end
  end

  assign io.x               = x_q;
  assign io.y               = y_q;
  assign io.in_air          = air_q;
  assign io.move_state      = ms_q;
  assign io.character_state = st_q;
  assign io.mirror          = mir_q;
  assign io.tick            = tick_w;

endmodule
